// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// holds on cache Stall, and latches a sticky flag on unsupported opcodes.
module multicycle_control_unit #(
  parameter int unsigned ALUCTRL_W = 3,
  parameter bit          EN_BNE    = 1'b1,
  parameter int unsigned STATE_W   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [6:0]           Opcode,
  input  logic [2:0]           Funct3,
  input  logic                 Funct7_5,
  input  logic                 Zero,
  input  logic                 Stall,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Illegal,
  output logic [STATE_W-1:0]   State
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  state_t     state;
  state_t     state_nxt;
  state_t     dec_state;
  alu_op_t    alu_op;
  logic [2:0] alu_ctrl;
  logic       illegal_q;

  // State register and sticky illegal flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      illegal_q <= illegal_q | (state_nxt == ILLEGAL);
    end
  end

  // Next-state and Moore output decode; reset decodes as FETCH with enables off
  always_comb begin
    state_nxt = FETCH;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALU_ADD;
    dec_state = RST ? FETCH : state;

    unique case (dec_state)
      FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = ~Stall;
        PCWrite   = ~Stall;
        state_nxt = Stall ? FETCH : DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (Opcode)
          OP_LOAD, OP_STORE: state_nxt = MEMADR;
          OP_RTYPE:          state_nxt = EXECR;
          OP_ITYPE:          state_nxt = EXECI;
          OP_BR:             state_nxt = BRANCH;
          OP_JAL:            state_nxt = JAL;
          default:           state_nxt = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        state_nxt = Opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc    = 1'b1;
        MemRead   = 1'b1;
        state_nxt = Stall ? MEMREAD : MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
        state_nxt = Stall ? MEMWRITE : FETCH;
      end
      EXECR: begin
        ALUSrcA   = 2'b10;
        alu_op    = ALU_FUNCT;
        state_nxt = ALUWB;
      end
      EXECI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        alu_op    = ALU_FUNCT;
        state_nxt = ALUWB;
      end
      ALUWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = ALU_SUB;
        if (Funct3 == 3'b000)               PCWrite = Zero;
        else if (EN_BNE && Funct3 == 3'b001) PCWrite = ~Zero;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        PCWrite   = 1'b1;
        state_nxt = ALUWB;
      end
      ILLEGAL: state_nxt = ILLEGAL;
      default: state_nxt = FETCH;
    endcase

    if (RST) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  // ALU operation decode
  always_comb begin
    alu_ctrl = 3'b000;
    case (alu_op)
      ALU_SUB: alu_ctrl = 3'b001;
      ALU_FUNCT: begin
        case (Funct3)
          3'b000:  alu_ctrl = (Opcode[5] & Funct7_5) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl = 3'b101;
          3'b110:  alu_ctrl = 3'b011;
          3'b111:  alu_ctrl = 3'b010;
          default: alu_ctrl = 3'b000;
        endcase
      end
      default: alu_ctrl = 3'b000;
    endcase
  end

  // Immediate format from opcode
  always_comb begin
    case (Opcode)
      OP_STORE: ImmSrc = 2'b01;
      OP_BR:    ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  assign ALUControl = ALUCTRL_W'(alu_ctrl);
  assign Illegal    = illegal_q;
  assign State      = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: instruction-level reference model
// predicts every cycle's outputs for an EN_BNE=1 and an EN_BNE=0 instance.
module tb_multicycle_control_unit;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                 S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9,
                 S_JAL = 10, S_ILLEGAL = 11;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, irw, mrd, mwr, rgw;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    logic       ill;
  } obs_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [6:0] Opcode = 7'd0;
  logic [2:0] Funct3 = 3'd0;
  logic       Funct7_5 = 1'b0, Zero = 1'b0, Stall = 1'b0;

  logic       pcw, adr, irw, mrd, mwr, rgw, ill;
  logic [1:0] res, sa, sb, imm;
  logic [2:0] alu;
  logic [3:0] st;
  logic       pcw0, adr0, irw0, mrd0, mwr0, rgw0, ill0;
  logic [1:0] res0, sa0, sb0, imm0;
  logic [2:0] alu0;
  logic [3:0] st0;

  obs_t exp_q[$];
  obs_t exp0_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;
  bit   ill_flag = 1'b0;
  bit   br_zero = 1'b0;

  always #5 CLK = ~CLK;

  multicycle_control_unit #(.ALUCTRL_W(3), .EN_BNE(1'b1), .STATE_W(4)) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct3(Funct3), .Funct7_5(Funct7_5),
    .Zero(Zero), .Stall(Stall), .PCWrite(pcw), .AdrSrc(adr), .IRWrite(irw),
    .MemRead(mrd), .MemWrite(mwr), .RegWrite(rgw), .ResultSrc(res), .ALUSrcA(sa),
    .ALUSrcB(sb), .ImmSrc(imm), .ALUControl(alu), .Illegal(ill), .State(st));

  multicycle_control_unit #(.ALUCTRL_W(3), .EN_BNE(1'b0), .STATE_W(4)) dut_nobne (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct3(Funct3), .Funct7_5(Funct7_5),
    .Zero(Zero), .Stall(Stall), .PCWrite(pcw0), .AdrSrc(adr0), .IRWrite(irw0),
    .MemRead(mrd0), .MemWrite(mwr0), .RegWrite(rgw0), .ResultSrc(res0), .ALUSrcA(sa0),
    .ALUSrcB(sb0), .ImmSrc(imm0), .ALUControl(alu0), .Illegal(ill0), .State(st0));

  function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic op5, input logic f7);
    case (f3)
      3'b000:  return (op5 && f7) ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Expected observation for one cycle spent in step st of the instruction
  function automatic obs_t model(input int s, input bit rst, input bit bne_en);
    obs_t e;
    int   d;
    e = '0;
    e.st  = 4'(s);
    e.ill = ill_flag;
    e.imm = (Opcode == OP_STORE) ? 2'd1 : (Opcode == OP_BR) ? 2'd2 :
            (Opcode == OP_JAL) ? 2'd3 : 2'd0;
    d = rst ? S_FETCH : s;
    case (d)
      S_FETCH:    begin e.mrd = 1; e.sb = 2; e.res = 2; e.pcw = ~Stall; e.irw = ~Stall; end
      S_DECODE:   begin e.sa = 1; e.sb = 1; end
      S_MEMADR:   begin e.sa = 2; e.sb = 1; end
      S_MEMREAD:  begin e.adr = 1; e.mrd = 1; end
      S_MEMWB:    begin e.res = 1; e.rgw = 1; end
      S_MEMWRITE: begin e.adr = 1; e.mwr = 1; end
      S_EXECR:    begin e.sa = 2; e.alu = funct_alu(Funct3, Opcode[5], Funct7_5); end
      S_EXECI:    begin e.sa = 2; e.sb = 1; e.alu = funct_alu(Funct3, Opcode[5], Funct7_5); end
      S_ALUWB:    e.rgw = 1;
      S_BRANCH: begin
        e.sa = 2; e.alu = 3'd1;
        if (Funct3 == 3'b000) e.pcw = Zero;
        else if (Funct3 == 3'b001 && bne_en) e.pcw = ~Zero;
      end
      S_JAL:      begin e.sa = 1; e.sb = 2; e.pcw = 1; end
      default:    ;
    endcase
    if (rst) begin e.pcw = 0; e.irw = 0; e.mrd = 0; e.mwr = 0; e.rgw = 0; end
    return e;
  endfunction

  // Monitor: pop one expectation per cycle for each instance and compare
  always @(negedge CLK) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{st: st, pcw: pcw, adr: adr, irw: irw, mrd: mrd, mwr: mwr, rgw: rgw,
            res: res, sa: sa, sb: sb, imm: imm, alu: alu, ill: ill};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle%0d en_bne1: got %h expected %h (state got %0d exp %0d)",
                 ncyc, a, e, a.st, e.st);
      end
    end
    if (exp0_q.size() > 0) begin
      e = exp0_q.pop_front();
      a = '{st: st0, pcw: pcw0, adr: adr0, irw: irw0, mrd: mrd0, mwr: mwr0, rgw: rgw0,
            res: res0, sa: sa0, sb: sb0, imm: imm0, alu: alu0, ill: ill0};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle%0d en_bne0: got %h expected %h (state got %0d exp %0d)",
                 ncyc, a, e, a.st, e.st);
      end
    end
    ncyc++;
  end

  task automatic cyc(input int s, input bit stall);
    Stall = stall;
    Zero  = (s == S_BRANCH) ? br_zero : 1'($urandom);
    exp_q.push_back(model(s, 1'b0, 1'b1));
    exp0_q.push_back(model(s, 1'b0, 1'b0));
    @(posedge CLK); #1;
  endtask

  task automatic do_reset(input int cur);
    RST   = 1'b1;
    Stall = 1'($urandom);
    exp_q.push_back(model(cur, 1'b1, 1'b1));
    exp0_q.push_back(model(cur, 1'b1, 1'b0));
    @(posedge CLK); #1;
    RST      = 1'b0;
    ill_flag = 1'b0;
  endtask

  // One instruction: fs FETCH stalls, ms memory stalls; hold leaves it stuck in memory
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input bit f7,
                           input bit z, input int fs, input int ms, input bit hold);
    Opcode = op; Funct3 = f3; Funct7_5 = f7; br_zero = z;
    repeat (fs) cyc(S_FETCH, 1'b1);
    cyc(S_FETCH, 1'b0);
    cyc(S_DECODE, 1'($urandom));
    case (op)
      OP_LOAD: begin
        cyc(S_MEMADR, 1'($urandom));
        repeat (ms) cyc(S_MEMREAD, 1'b1);
        if (!hold) begin cyc(S_MEMREAD, 1'b0); cyc(S_MEMWB, 1'($urandom)); end
      end
      OP_STORE: begin
        cyc(S_MEMADR, 1'($urandom));
        repeat (ms) cyc(S_MEMWRITE, 1'b1);
        if (!hold) cyc(S_MEMWRITE, 1'b0);
      end
      OP_RTYPE: begin cyc(S_EXECR, 1'($urandom)); cyc(S_ALUWB, 1'($urandom)); end
      OP_ITYPE: begin cyc(S_EXECI, 1'($urandom)); cyc(S_ALUWB, 1'($urandom)); end
      OP_BR:    cyc(S_BRANCH, 1'($urandom));
      OP_JAL:   begin cyc(S_JAL, 1'($urandom)); cyc(S_ALUWB, 1'($urandom)); end
      default: begin
        ill_flag = 1'b1;
        repeat (20) cyc(S_ILLEGAL, 1'($urandom));
      end
    endcase
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: time limit reached, got %0d cycles expected completion", ncyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [6:0] ops [6];
    ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BR, OP_JAL};
    @(posedge CLK); #1;
    do_reset(S_FETCH);

    run_instr(OP_RTYPE, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_RTYPE, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0);
    run_instr(OP_ITYPE, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0);
    run_instr(OP_ITYPE, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_LOAD,  3'b010, 1'b0, 1'b0, 0, 3, 1'b0);
    run_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 2, 2, 1'b0);
    run_instr(OP_BR,    3'b000, 1'b0, 1'b1, 0, 0, 1'b0);
    run_instr(OP_BR,    3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_BR,    3'b001, 1'b0, 1'b1, 0, 0, 1'b0);
    run_instr(OP_BR,    3'b001, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_BR,    3'b100, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_JAL,   3'b000, 1'b0, 1'b0, 0, 0, 1'b0);

    repeat (80) begin
      run_instr(ops[$urandom_range(0, 5)], 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    end

    run_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 0, 2, 1'b1);
    do_reset(S_MEMWRITE);
    run_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 1, 3, 1'b1);
    do_reset(S_MEMREAD);
    run_instr(OP_RTYPE, 3'b111, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    do_reset(S_ILLEGAL);
    run_instr(OP_ITYPE, 3'b110, 1'b0, 1'b0, 0, 0, 1'b0);

    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0 || exp0_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expectations expected 0/0",
               exp_q.size(), exp0_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- FSM-based control unit for the multicycle RV32I core. It drives a shared instruction/data port that sits behind the write-through cache.
- Generalises the single-cycle controller in four ways:
  - sequences each instruction over 3-5 states;
  - holds on the cache Stall handshake;
  - adds optional bne support;
  - flags unsupported opcodes.
- ALU and immediate decode stay combinational. Sequencing and the Illegal flag are registered.

Parameters:
- ALUCTRL_W, 3: width of ALUControl. Values >3 zero-extend the MSBs.
- EN_BNE, 1: 1 = funct3 001 branch decodes as bne; 0 = treated as not-taken.
- STATE_W, 4: width of the State debug port. Must be >=4.

Ports:
- CLK  in  1  core clock, rising edge
- RST  in  1  synchronous active-high reset
- Opcode  in  7  instruction[6:0] from the IR
- Funct3  in  3  instruction[14:12]
- Funct7_5  in  1  instruction[30]
- Zero  in  1  ALU zero flag
- Stall  in  1  cache busy; memory access not complete this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  IR and OldPC enable
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = Imm, 10 = 4
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  ALUCTRL_W  ALU operation
- Illegal  out  1  sticky unsupported-opcode flag
- State  out  STATE_W  current state code

Behaviour:

Reset:
- RST=1 at a clock edge: State <= FETCH(0) and Illegal <= 0.
- While RST=1: PCWrite, IRWrite, MemRead, MemWrite and RegWrite are forced to 0. All other outputs decode as in FETCH.
- RST overrides every state, including stalled MEMREAD, MEMWRITE and ILLEGAL.

Output defaults and timing:
- Outputs are Moore decodes of State, except PCWrite and IRWrite, which are also gated by Stall/Zero as stated below.
- Defaults: all enables 0, selects 00, ALUOp add.

ImmSrc (combinational from Opcode):
- 0100011 (store) -> 01
- 1100011 (branch) -> 10
- 1101111 (jal) -> 11
- all other opcodes -> 00

ALUControl:
- ALUOp add -> 000; ALUOp sub -> 001.
- ALUOp funct decode, by Funct3:
  - 000 -> 001 if (Opcode[5] & Funct7_5), else 000
  - 010 -> 101
  - 110 -> 011
  - 111 -> 010
  - others -> 000

States, outputs and transitions:
- FETCH(0): AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite = PCWrite = ~Stall. Stall=1 -> stay in FETCH; else -> DECODE.
- DECODE(1): ALUSrcA=01, ALUSrcB=01, add (branch/jal target into ALUOut). Next state by Opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other value -> ILLEGAL
- MEMADR(2): ALUSrcA=10, ALUSrcB=01, add. Opcode[5]=0 -> MEMREAD; else -> MEMWRITE.
- MEMREAD(3): AdrSrc=1, MemRead=1, ResultSrc=00. Stall=1 -> hold; else -> MEMWB.
- MEMWB(4): ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE(5): AdrSrc=1, MemWrite=1 on every cycle in this state, ResultSrc=00. Stall=1 -> hold (write-through completes downstream); else -> FETCH.
- EXECR(6): ALUSrcA=10, ALUSrcB=00, funct decode -> ALUWB.
- EXECI(7): ALUSrcA=10, ALUSrcB=01, funct decode -> ALUWB.
- ALUWB(8): ResultSrc=00, RegWrite=1 -> FETCH.
- BRANCH(9): ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite:
  - Funct3=000: PCWrite = Zero
  - Funct3=001 with EN_BNE=1: PCWrite = ~Zero
  - otherwise: PCWrite = 0
  - -> FETCH in all cases.
- JAL(10): ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB (rd <= OldPC+4).
- ILLEGAL(11): Illegal=1, all enables 0. Stays in ILLEGAL until RST.

Boundary conditions and latency:
- Stall is ignored in every state except FETCH, MEMREAD and MEMWRITE.
- Stall held indefinitely -> the FSM holds indefinitely with no timeout.
- Unused state codes 12-15 -> next state is FETCH, all enables 0.
- Cycles per instruction with zero stall:
  - R/I-type: 4
  - lw: 5
  - sw: 4
  - branch: 3
  - jal: 4
  - each stall cycle adds 1.

Test Plan:
1. add (Opcode 0110011, Funct3 000, Funct7_5 0), Stall=0 -> State sequence 0,1,6,8,0. ALUControl=000 in EXECR. RegWrite=1 only in ALUWB. Changing Funct7_5 to 1 gives ALUControl=001 in EXECR.
2. lw with Stall=1 for 3 cycles on entering MEMREAD -> 8 cycles total. MemRead=1 and AdrSrc=1 held for 4 cycles. RegWrite=1 and ResultSrc=01 exactly once.
3. sw with Stall=1 for 2 cycles in MEMWRITE -> MemWrite=1 for 3 consecutive cycles, then FETCH. RegWrite is never asserted. FETCH with Stall=1 for 2 cycles shows IRWrite=PCWrite=0 on those cycles.
4. Branch tests:
   - beq with Zero=1 -> PCWrite=1 in BRANCH, ALUControl=001.
   - bne with Zero=1 -> PCWrite=0.
   - bne with Zero=0 -> PCWrite=1.
   - Repeat with EN_BNE=0 -> bne never asserts PCWrite.
5. jal -> States 0,1,10,8,0. In JAL, PCWrite=1 and ResultSrc=00. ImmSrc=11 throughout the instruction.
6. Opcode 0000000 -> Illegal=1 from the cycle after DECODE and stays 1 for 20 cycles. Then RST pulse during ILLEGAL, and separately during stalled MEMWRITE -> State=0 next cycle, Illegal=0, MemWrite=0 while RST=1.
